jk_counter_ctrl: RTL and testbench
==================================

// Module: jk_counter_ctrl
// PURPOSE
//  Controller that sequences a bank of WIDTH JK flip-flop cells as a programmable up/down counter.
//  Each cycle it computes the desired next count and drives per-bit J/K excitation plus cell enables.
//  It also provides start/stop/load control, terminal-count detection and a done pulse.
//  Used wherever the design needs a modulus counter built from the shared JK cell; the timer/sequencer layer sits above it.
// PARAMETERS
//  WIDTH        4  counter / JK bank width in bits
//  AUTO_RELOAD  0  1: wrap at terminal count and keep running; 0: stop at terminal count, pulse done
// PORTS
//  clk       in   1      single clock, all state updates on posedge
//  reset     in   1      synchronous, active-high; clears everything on the next posedge
//  start     in   1      begin counting (IDLE), resume (HOLD)
//  stop      in   1      pause (RUN->HOLD), abort (HOLD->IDLE)
//  up_dn     in   1      1 = count up, 0 = count down; sampled on an accepted start from IDLE
//  load      in   1      parallel load request; honoured only in IDLE, HOLD or DONE
//  load_val  in   WIDTH  value for load
//  mod_val   in   WIDTH  terminal value; registered into mod_q on an accepted start from IDLE
//  q         out  WIDTH  counter value = outputs of the JK bank
//  busy      out  1      1 while state is RUN or HOLD
//  tc        out  1      combinational: state==RUN && q==end_val
//  done      out  1      1-cycle pulse, asserted exactly while state==DONE
// BEHAVIOUR
//  - Reset: state=IDLE, q=0, mod_q=0, dir_q=1 (up), busy=0, tc=0, done=0. Reset overrides every input in every state.
//  - States: IDLE, RUN, HOLD, DONE. Transitions are evaluated on posedge, in priority order:
//    IDLE: start -> RUN (latch dir_q=up_dn, mod_q=mod_val). Otherwise stay.
//    RUN:  stop -> HOLD. Else tc && !AUTO_RELOAD -> DONE. Else stay.
//    HOLD: stop -> IDLE (q retained). Else start -> RUN (dir_q/mod_q are not re-sampled). Else stay.
//    DONE: -> IDLE unconditionally, after one cycle.
//  - stop and start together: stop wins in every state.
//  - Terminal value: end_val = dir_q ? mod_q : 0.
//    Wrap value: wrap_val = dir_q ? 0 : mod_q.
//  - Next-count selection, driven into the bank:
//    RUN, !tc: nxt = q +/- 1, mod 2^WIDTH. The counter passes through the full range when q lies outside [0, mod_q].
//    RUN, tc, AUTO_RELOAD=1: nxt = wrap_val.
//    RUN, tc, AUTO_RELOAD=0: hold, en=0.
//    RUN, stop asserted: hold. stop takes priority over stepping; q is frozen on that edge.
//    IDLE/HOLD/DONE with load: nxt = load_val. The state is unchanged.
//    Otherwise: hold, en=0.
//  - Excitation per bit i: J[i] = nxt[i] & ~q[i], K[i] = ~nxt[i] & q[i], en = 1 only when nxt != q.
//    The toggle case J=K=1 is never driven.
//  - Latency: start sampled at edge N -> state RUN after N; first step lands at edge N+1.
//    The load value appears on q one cycle after load is sampled.
//  - load during RUN is ignored.
//  - mod_val==0 in up mode: tc=1 in the first RUN cycle. With AUTO_RELOAD=0 this goes to DONE with q unchanged.
//  - Inputs in DONE (other than reset and load) are ignored.
// STRUCTURE
//  - Shared package/include jk_ctrl_pkg: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2, ST_DONE=2'd3; DIR_UP=1'b1, DIR_DN=1'b0.
//  - One sub-module, jk_cell (ports q, j, k, en, clk, reset; synchronous active-high reset), instantiated WIDTH times in a generate loop.
//  - The controller contains: FSM register, mod_q/dir_q registers, next-count mux, J/K excitation logic.
//  - No arithmetic other than the +/-1 adder and the equality compare.
// TESTING
//  1. Reset, then WIDTH=4, mod_val=5, up_dn=1, start pulse -> q steps 0..5 one per cycle; tc=1 at q=5; done pulses once; busy falls; final q=5.
//  2. AUTO_RELOAD=1, mod_val=3, down, load 3 then start -> q sequence 3,2,1,0,3,2,... with tc high at each q=0; done never asserted.
//  3. Counting up at q=2, stop for 3 cycles, then start -> q frozen at 2, busy=1; resumes 3 on the cycle after start.
//  4. Assert start and stop in the same cycle in IDLE -> stays IDLE. In HOLD -> goes IDLE with q retained.
//  5. Load 14 with mod_val=2, up, start -> q 14,15,0,1,2 then done. Load asserted while in RUN -> no effect.
//  6. Assert reset during RUN at q=4 -> next cycle q=0, state IDLE, busy/tc/done all 0. Check J/K are never both 1 (assertion).

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK-cell counter controller.
//   State encodings for the controller FSM and the count-direction constants.
package jk_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_HOLD = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell with clock enable.
//   clk   : clock, state updates on posedge
//   reset : synchronous active-high reset, clears q
//   j, k  : JK excitation (00 hold, 01 clear, 10 set, 11 toggle)
//   en    : cell enable; when low the cell holds
//   q     : cell output
module jk_cell (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   input  logic en,
   output logic q
);

   logic q_d;

   always_comb begin
      q_d = q;
      if (en) begin
         unique case ({j, k})
            2'b00:   q_d = q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) q <= 1'b0;
      else       q <= q_d;
   end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Programmable up/down counter built from a bank of WIDTH JK cells.
//   The controller computes the desired next count every cycle and excites
//   each cell with J/K so the bank lands on it; the bank itself is the count.
// Ports:
//   clk      : clock
//   reset    : synchronous active-high reset
//   start    : begin counting (IDLE) / resume (HOLD)
//   stop     : pause (RUN->HOLD) / abort (HOLD->IDLE); beats start
//   up_dn    : direction, latched on an accepted start from IDLE
//   load     : parallel load, honoured in IDLE, HOLD and DONE
//   load_val : value to load
//   mod_val  : terminal value, latched on an accepted start from IDLE
//   q        : counter value (JK bank outputs)
//   busy     : RUN or HOLD
//   tc       : terminal count reached while running
//   done     : one-cycle pulse while in DONE
module jk_counter_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter bit          AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] mod_val,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] One = 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mod_q, mod_d;
   logic             dir_q, dir_d;

   logic [WIDTH-1:0] end_val, wrap_val, step_val, nxt;
   logic [WIDTH-1:0] j_bits, k_bits;
   logic             en;

   assign end_val  = (dir_q == DIR_UP) ? mod_q : '0;
   assign wrap_val = (dir_q == DIR_UP) ? '0 : mod_q;
   // Plain modular step: a start value outside [0, mod_q] runs the full range.
   assign step_val = (dir_q == DIR_UP) ? q + One : q - One;

   assign tc   = (state_q == ST_RUN) && (q == end_val);
   assign busy = (state_q == ST_RUN) || (state_q == ST_HOLD);
   assign done = (state_q == ST_DONE);

   // FSM and latched configuration
   always_comb begin
      state_d = state_q;
      mod_d   = mod_q;
      dir_d   = dir_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_RUN;
               mod_d   = mod_val;
               dir_d   = up_dn;
            end
         end
         ST_RUN: begin
            if (stop)                   state_d = ST_HOLD;
            else if (tc && !AUTO_RELOAD) state_d = ST_DONE;
         end
         ST_HOLD: begin
            if (stop)       state_d = ST_IDLE;
            else if (start) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next-count mux; defaults to holding the bank
   always_comb begin
      nxt = q;
      if (state_q == ST_RUN) begin
         if (!stop) begin
            if (!tc)             nxt = step_val;
            else if (AUTO_RELOAD) nxt = wrap_val;
         end
      end else if (load) begin
         nxt = load_val;
      end
   end

   // Set/clear only the bits that change, so J=K=1 never occurs.
   assign j_bits = nxt & ~q;
   assign k_bits = ~nxt & q;
   assign en     = (nxt != q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mod_q   <= '0;
         dir_q   <= DIR_UP;
      end else begin
         state_q <= state_d;
         mod_q   <= mod_d;
         dir_q   <= dir_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j_bits[i]),
         .k     (k_bits[i]),
         .en    (en),
         .q     (q[i])
      );
   end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
module tb_jk_counter_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, stop, up_dn, load;
   logic [3:0] load_val, mod_val;
   logic [3:0] q0, q1;
   logic       busy0, busy1, tc0, tc1, done0, done1;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      string      tag;
      int         which;
      logic [3:0] q;
      logic       busy;
      logic       tc;
      logic       done;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   jk_counter_ctrl #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .up_dn(up_dn),
      .load(load), .load_val(load_val), .mod_val(mod_val),
      .q(q0), .busy(busy0), .tc(tc0), .done(done0)
   );

   jk_counter_ctrl #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .up_dn(up_dn),
      .load(load), .load_val(load_val), .mod_val(mod_val),
      .q(q1), .busy(busy1), .tc(tc1), .done(done1)
   );

   // The excitation must never request a toggle in either bank.
   always @(negedge clk) begin
      n_checks++;
      assert (((dut0.j_bits & dut0.k_bits) === 4'd0) && ((dut1.j_bits & dut1.k_bits) === 4'd0))
      else begin
         n_err++;
         $error("FAIL jk_toggle observed j0=%b k0=%b j1=%b k1=%b expected no J=K=1",
                dut0.j_bits, dut0.k_bits, dut1.j_bits, dut1.k_bits);
      end
   end

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Push the expectation for the coming edge, clock, then pop and compare.
   task automatic step(input string tag, input int which, input logic [3:0] eq,
                       input logic eb, input logic et, input logic ed);
      exp_t e;
      logic [3:0] oq;
      logic ob, ot, od;
      e.tag = tag; e.which = which; e.q = eq; e.busy = eb; e.tc = et; e.done = ed;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.which == 0) begin
         oq = q0; ob = busy0; ot = tc0; od = done0;
      end else begin
         oq = q1; ob = busy1; ot = tc1; od = done1;
      end
      chk({e.tag, ".q"},    oq,          e.q);
      chk({e.tag, ".busy"}, {3'b0, ob},  {3'b0, e.busy});
      chk({e.tag, ".tc"},   {3'b0, ot},  {3'b0, e.tc});
      chk({e.tag, ".done"}, {3'b0, od},  {3'b0, e.done});
   endtask

   task automatic do_reset(input int which);
      reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
      step("reset", which, 4'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; up_dn = 1'b1; load = 1'b0;
      load_val = 4'd0; mod_val = 4'd0;
      @(posedge clk);
      #1;

      // 1: up count 0..5, done pulse, stop at terminal
      do_reset(0);
      mod_val = 4'd5; up_dn = 1'b1; start = 1'b1;
      step("t1_start", 0, 4'd0, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      for (int i = 1; i <= 4; i++) step("t1_cnt", 0, 4'(i), 1'b1, 1'b0, 1'b0);
      step("t1_tc",    0, 4'd5, 1'b1, 1'b1, 1'b0);
      step("t1_done",  0, 4'd5, 1'b0, 1'b0, 1'b1);
      step("t1_idle",  0, 4'd5, 1'b0, 1'b0, 1'b0);

      // 2: auto-reload down count from 3
      do_reset(1);
      mod_val = 4'd3; up_dn = 1'b0; load = 1'b1; load_val = 4'd3;
      step("t2_load",  1, 4'd3, 1'b0, 1'b0, 1'b0);
      load = 1'b0; start = 1'b1;
      step("t2_start", 1, 4'd3, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      for (int r = 0; r < 2; r++) begin
         step("t2_c2",   1, 4'd2, 1'b1, 1'b0, 1'b0);
         step("t2_c1",   1, 4'd1, 1'b1, 1'b0, 1'b0);
         step("t2_c0",   1, 4'd0, 1'b1, 1'b1, 1'b0);
         step("t2_wrap", 1, 4'd3, 1'b1, 1'b0, 1'b0);
      end

      // 3: pause at 2, hold three cycles, resume
      do_reset(0);
      mod_val = 4'd9; up_dn = 1'b1; start = 1'b1;
      step("t3_start", 0, 4'd0, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      step("t3_c1", 0, 4'd1, 1'b1, 1'b0, 1'b0);
      step("t3_c2", 0, 4'd2, 1'b1, 1'b0, 1'b0);
      stop = 1'b1;
      step("t3_stop", 0, 4'd2, 1'b1, 1'b0, 1'b0);
      stop = 1'b0;
      for (int i = 0; i < 3; i++) step("t3_hold", 0, 4'd2, 1'b1, 1'b0, 1'b0);
      start = 1'b1;
      step("t3_resume", 0, 4'd2, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      step("t3_c3", 0, 4'd3, 1'b1, 1'b0, 1'b0);

      // 4: start+stop together in HOLD then IDLE
      stop = 1'b1;
      step("t4_hold", 0, 4'd3, 1'b1, 1'b0, 1'b0);
      start = 1'b1;
      step("t4_hold_both", 0, 4'd3, 1'b0, 1'b0, 1'b0);
      step("t4_idle_both", 0, 4'd3, 1'b0, 1'b0, 1'b0);
      start = 1'b0; stop = 1'b0;
      step("t4_idle", 0, 4'd3, 1'b0, 1'b0, 1'b0);

      // 5: load 14, wrap through 15/0 to mod 2; load during RUN ignored
      do_reset(0);
      load = 1'b1; load_val = 4'd14;
      step("t5_load", 0, 4'd14, 1'b0, 1'b0, 1'b0);
      load = 1'b0; mod_val = 4'd2; up_dn = 1'b1; start = 1'b1;
      step("t5_start", 0, 4'd14, 1'b1, 1'b0, 1'b0);
      start = 1'b0; load = 1'b1; load_val = 4'd7;
      step("t5_c15", 0, 4'd15, 1'b1, 1'b0, 1'b0);
      load = 1'b0;
      step("t5_c0",   0, 4'd0, 1'b1, 1'b0, 1'b0);
      step("t5_c1",   0, 4'd1, 1'b1, 1'b0, 1'b0);
      step("t5_tc",   0, 4'd2, 1'b1, 1'b1, 1'b0);
      step("t5_done", 0, 4'd2, 1'b0, 1'b0, 1'b1);

      // 6: reset during RUN at q=4
      do_reset(0);
      mod_val = 4'd9; up_dn = 1'b1; start = 1'b1;
      step("t6_start", 0, 4'd0, 1'b1, 1'b0, 1'b0);
      start = 1'b0;
      for (int i = 1; i <= 4; i++) step("t6_cnt", 0, 4'(i), 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      step("t6_reset0", 0, 4'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step("t6_reset1", 1, 4'd0, 1'b0, 1'b0, 1'b0);

      // mod_val 0 in up mode: immediate terminal count, then done
      mod_val = 4'd0; up_dn = 1'b1; start = 1'b1;
      step("t7_start", 0, 4'd0, 1'b1, 1'b1, 1'b0);
      start = 1'b0;
      step("t7_done", 0, 4'd0, 1'b0, 1'b0, 1'b1);
      step("t7_idle", 0, 4'd0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
